// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types, used by reg_file and by the
// write-port arbiter that feeds it.
package reg_file_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [AW-1:0] ZERO_REG = '0;

  // Encoding of the remembered winner; rr_arb2 favours the other side.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [AW-1:0] rw;
    logic [DW-1:0] data;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller owns lastGrant
// so the same block can be reused for read-port sharing.
module rr_arb2
  import reg_file_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic [1:0] gnt
);

  // A lone requester always wins; on contention the previous loser wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (lastGrant == GRANT_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Owns reg_file's single write port: zero-fills r1..r(NREG-1) after reset,
// then shares the port between ALU writeback (A) and load writeback (B).
module reg_write_arbiter
  import reg_file_pkg::*;
#(
  parameter int NREG    = reg_file_pkg::NREG,
  parameter int AW      = reg_file_pkg::AW,
  parameter int DW      = reg_file_pkg::DW,
  parameter bit INIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rw,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_rw,
  input  logic [DW-1:0] b_data,
  output logic          RegWr,
  output logic [AW-1:0] Rw,
  output logic [DW-1:0] busW,
  output logic          init_done
);

  state_t        state, stateNext;
  logic [AW:0]   cnt, cntNext;
  logic          lastGrant, lastGrantNext;
  logic          regWrNext;
  logic [AW-1:0] rwNext;
  logic [DW-1:0] busWNext;
  logic          initDoneNext;
  logic [1:0]    gnt;
  logic          isRun;
  logic          aXfer, bXfer;
  req_t          sel;

  rr_arb2 uArb (
    .req      ({b_valid, a_valid}),
    .lastGrant(lastGrant),
    .gnt      (gnt)
  );

  assign isRun   = (state == RUN);
  assign a_ready = isRun & gnt[0];
  assign b_ready = isRun & gnt[1];
  assign aXfer   = a_valid & a_ready;
  assign bXfer   = b_valid & b_ready;
  assign sel     = gnt[1] ? '{rw: b_rw, data: b_data} : '{rw: a_rw, data: a_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT_EN ? INIT : RUN;
      cnt       <= (AW+1)'(1);
      lastGrant <= GRANT_B;
      RegWr     <= 1'b0;
      Rw        <= '0;
      busW      <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      lastGrant <= lastGrantNext;
      RegWr     <= regWrNext;
      Rw        <= rwNext;
      busW      <= busWNext;
      init_done <= initDoneNext;
    end
  end

  // cnt reaching NREG (one past the last register) marks the end of the fill;
  // register 0 is skipped in both phases.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    lastGrantNext = lastGrant;
    regWrNext     = 1'b0;
    rwNext        = Rw;
    busWNext      = busW;
    initDoneNext  = init_done;
    case (state)
      INIT: begin
        if (cnt == (AW+1)'(NREG)) begin
          stateNext    = RUN;
          initDoneNext = 1'b1;
        end else begin
          regWrNext = 1'b1;
          rwNext    = cnt[AW-1:0];
          busWNext  = '0;
          cntNext   = cnt + 1'b1;
        end
      end
      RUN: begin
        initDoneNext = 1'b1;
        if (aXfer || bXfer) begin
          lastGrantNext = bXfer ? GRANT_B : GRANT_A;
          if (sel.rw != ZERO_REG) begin
            regWrNext = 1'b1;
            rwNext    = sel.rw;
            busWNext  = sel.data;
          end
        end
      end
      default: stateNext = INIT;
    endcase
  end

endmodule
